// File: rtl/tally_serializer_if.sv
// Handshake bundle for tally_serializer: code input channel, serial beat output, status.
interface tally_serializer_if #(
  parameter int unsigned N = 6
);
  logic         in_valid;
  logic         in_ready;
  logic [N:0]   in_code;
  logic         out_valid;
  logic         out_ready;
  logic         out_bit;
  logic         out_last;
  logic [N-1:0] therm;
  logic         err;

  modport master (
    output in_valid,
    output in_code,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bit,
    input  out_last,
    input  therm,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_code,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bit,
    output out_last,
    output therm,
    output err
  );
endinterface

// File: rtl/tally_serializer.sv
// Turns a one-hot tally code k into an N-beat serial stream (k ones, then N-k zeros)
// and latches the matching low-aligned thermometer; malformed codes pulse err.
module tally_serializer #(
  parameter int unsigned N = 6
) (
  input logic              clk,
  input logic              rst_n,
  tally_serializer_if.slave bus
);

  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StEmit = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [N-1:0]  therm_q, therm_d;
  logic          err_q, err_d;

  logic [CW-1:0] code_idx;
  logic          code_seen;
  logic          code_multi;
  logic          code_ok;
  logic [N-1:0]  code_therm;
  logic          at_last;

  // Position of the set bit, plus a flag for zero or multiple set bits.
  always_comb begin
    code_idx   = '0;
    code_seen  = 1'b0;
    code_multi = 1'b0;
    for (int unsigned i = 0; i <= N; i++) begin
      if (bus.in_code[i]) begin
        if (code_seen) begin
          code_multi = 1'b1;
        end
        code_seen = 1'b1;
        code_idx  = CW'(i);
      end
    end
    code_ok = code_seen & ~code_multi;
  end

  always_comb begin
    code_therm = '0;
    for (int unsigned i = 0; i < N; i++) begin
      code_therm[i] = (CW'(i) < code_idx);
    end
  end

  assign at_last = (beat_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    therm_d = therm_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (code_ok) begin
            k_d     = code_idx;
            beat_d  = '0;
            therm_d = code_therm;
            state_d = StEmit;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          if (at_last) begin
            state_d = StIdle;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      beat_q  <= '0;
      therm_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      therm_q <= therm_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode only from registered state, so there is no input-to-output path.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StEmit);
  assign bus.out_bit   = (state_q == StEmit) && (beat_q < k_q);
  assign bus.out_last  = (state_q == StEmit) && at_last;
  assign bus.therm     = therm_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_tally_serializer.sv
// Directed and randomized bench for tally_serializer against a queue-based stream model.
module tb_tally_serializer;
  localparam int unsigned N = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tally_serializer_if #(.N(N)) bus();

  tally_serializer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: count encoded by a one-hot code (caller only passes legal codes).
  function automatic int code_count(input logic [N:0] code);
    int k = 0;
    for (int i = 0; i <= N; i++) if (code[i]) k = i;
    return k;
  endfunction

  // Send one legal code and collect its stream; called at a falling edge, returns at one.
  task automatic run_code(input logic [N:0] code, input int stall_pct,
                          output logic [N-1:0] got_stream, output int got_ones);
    int k;
    bit exp_q[$];
    int beat;
    int cycles;
    bit rdy;
    logic [N-1:0] exp_therm;
    k = code_count(code);
    exp_q = {};
    for (int i = 0; i < k; i++) exp_q.push_back(1'b1);
    for (int i = k; i < N; i++) exp_q.push_back(1'b0);
    exp_therm = N'((64'd1 << k) - 64'd1);
    got_stream = '0;
    got_ones = 0;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_code  = '0;
    check("accept_err", 32'(bus.err), 32'd0);
    check("accept_in_ready", 32'(bus.in_ready), 32'd0);
    beat = 0;
    cycles = 0;
    while (beat < N && cycles < 400) begin
      check("beat_valid", 32'(bus.out_valid), 32'd1);
      check("beat_bit", 32'(bus.out_bit), 32'(exp_q[beat]));
      check("beat_last", 32'(bus.out_last), 32'(beat == N - 1));
      rdy = ($urandom_range(99) >= stall_pct);
      bus.out_ready = rdy;
      if (rdy) begin
        got_stream[beat] = bus.out_bit;
        got_ones += int'(bus.out_bit);
      end
      @(negedge clk);
      if (rdy) beat++;
      cycles++;
    end
    check("beat_count", 32'(beat), 32'(N));
    bus.out_ready = 1'b0;
    check("done_valid", 32'(bus.out_valid), 32'd0);
    check("done_in_ready", 32'(bus.in_ready), 32'd1);
    check("therm", 32'(bus.therm), 32'(exp_therm));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] s;
    int o;
    logic [N-1:0] prior_therm;
    logic [N:0] code;
    logic [N:0] bad_codes [2];
    int unsigned val;

    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bit", 32'(bus.out_bit), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_therm", 32'(bus.therm), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // k=3 without stalls
    run_code(7'b0001000, 0, s, o);
    check("k3_stream", 32'(s), 32'h07);
    check("k3_ones", 32'(o), 32'd3);

    // Boundaries k=0 and k=N
    run_code(7'b0000001, 0, s, o);
    check("k0_stream", 32'(s), 32'h00);
    run_code(7'b1000000, 0, s, o);
    check("k6_stream", 32'(s), 32'h3f);

    // k=2 with 50% backpressure
    run_code(7'b0000100, 50, s, o);
    check("k2_stall_stream", 32'(s), 32'h03);

    // Malformed codes
    prior_therm = 6'b000011;
    bad_codes[0] = 7'b0011000;
    bad_codes[1] = 7'b0000000;
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = 1'b1;
      bus.in_code  = bad_codes[b];
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_code  = '0;
      check("bad_err_pulse", 32'(bus.err), 32'd1);
      check("bad_out_valid", 32'(bus.out_valid), 32'd0);
      check("bad_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      check("bad_err_clear", 32'(bus.err), 32'd0);
      check("bad_therm_kept", 32'(bus.therm), 32'(prior_therm));
      check("bad_no_valid", 32'(bus.out_valid), 32'd0);
    end

    // Reset in the middle of a stream
    bus.in_valid = 1'b1;
    bus.in_code  = 7'b0010000;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_valid_before", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_therm", 32'(bus.therm), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(bus.out_valid), 32'd0);
    run_code(7'b0000010, 30, s, o);
    check("post_rst_stream", 32'(s), 32'h01);

    // Round trip from random 6-bit inputs through an ideal tally
    for (int t = 0; t < 100; t++) begin
      val = $urandom_range(63);
      code = '0;
      code[$countones(val)] = 1'b1;
      run_code(code, 25, s, o);
      check("rt_ones", 32'(o), 32'($countones(val)));
      check("rt_therm_vs_stream", 32'(bus.therm), 32'(s));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
